// File: rtl/peripheral_mpram_banked_if.sv
// Native request/response bundle shared by all ports of the banked multi-port RAM.
// Each vector carries one lane per port; port p sits at slice [p*W +: W].
interface peripheral_mpram_banked_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]            req_i;
  logic [NUM_PORTS-1:0]            we_i;
  logic [NUM_PORTS*BE_W-1:0]       be_i;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0] data_i;
  logic [NUM_PORTS-1:0]            gnt_o;
  logic [NUM_PORTS-1:0]            rvalid_o;
  logic [NUM_PORTS*DATA_WIDTH-1:0] data_o;

  modport master (
    output req_i, we_i, be_i, addr_i, data_i,
    input  gnt_o, rvalid_o, data_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, data_i,
    output gnt_o, rvalid_o, data_o
  );
endinterface

// File: rtl/peripheral_mpram_banked.sv
// Multi-port, word-interleaved multi-bank SRAM. Each bank owns a round-robin
// arbiter so ports hitting different banks proceed in the same cycle. Grants are
// combinational; reads and write acks respond exactly one cycle after the grant.
module peripheral_mpram_banked #(
  parameter int NUM_PORTS  = 4,
  parameter int NUM_BANKS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  peripheral_mpram_banked_if.slave  bus
);
  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int OFF_LG = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int BNK_LG = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int BW     = (NUM_BANKS > 1) ? BNK_LG : 1;
  localparam int RW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Address bits above the row field are deliberately ignored (wrap-around).
  logic unused_addr;
  assign unused_addr = ^bus.addr_i;

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][DEPTH];

  logic [BW-1:0]         bank_of_p0 [NUM_PORTS];
  logic [RW-1:0]         row_of_p0  [NUM_PORTS];
  logic [PW-1:0]         rr_ptr     [NUM_BANKS];
  logic                  bank_act   [NUM_BANKS];
  logic                  bank_go    [NUM_BANKS];
  logic [PW-1:0]         bank_sel   [NUM_BANKS];
  logic                  bank_we    [NUM_BANKS];
  logic [BE_W-1:0]       bank_be    [NUM_BANKS];
  logic [RW-1:0]         bank_row   [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_wdata [NUM_BANKS];
  logic [NUM_PORTS-1:0]  gnt_p0;
  logic [NUM_PORTS-1:0]  vld_p1;
  logic [DATA_WIDTH-1:0] rdata_p1   [NUM_PORTS];

  // ---- stage p0: decode, arbitrate, grant ----

  // Split each port's byte address into bank index and row within the bank.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      bank_of_p0[p] = '0;
      row_of_p0[p]  = '0;
      if (NUM_BANKS > 1) bank_of_p0[p] = bus.addr_i[p*ADDR_WIDTH + OFF_LG +: BW];
      if (DEPTH > 1)     row_of_p0[p]  = bus.addr_i[p*ADDR_WIDTH + OFF_LG + BNK_LG +: RW];
    end
  end

  // Per-bank round-robin: first requesting port at or after rr_ptr wins, then steer its fields.
  always_comb begin
    int idx;
    idx = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_act[b] = 1'b0;
      bank_sel[b] = '0;
      for (int off = 0; off < NUM_PORTS; off++) begin
        idx = int'(rr_ptr[b]) + off;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (!bank_act[b] && bus.req_i[idx] && (bank_of_p0[idx] == BW'(b))) begin
          bank_act[b] = 1'b1;
          bank_sel[b] = idx[PW-1:0];
        end
      end
      bank_go[b]    = bank_act[b] & ~rst_i;
      bank_we[b]    = bus.we_i[bank_sel[b]];
      bank_be[b]    = bus.be_i[int'(bank_sel[b])*BE_W +: BE_W];
      bank_row[b]   = row_of_p0[bank_sel[b]];
      bank_wdata[b] = bus.data_i[int'(bank_sel[b])*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A port is granted when the bank it addresses selected it this cycle.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++)
      gnt_p0[p] = bank_go[bank_of_p0[p]] && (bank_sel[bank_of_p0[p]] == PW'(p));
  end

  assign bus.gnt_o = gnt_p0;

  // Advance each bank's pointer past the port it just served.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < NUM_BANKS; b++) rr_ptr[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++)
        if (bank_go[b])
          rr_ptr[b] <= (int'(bank_sel[b]) == NUM_PORTS - 1) ? '0 : bank_sel[b] + 1'b1;
    end
  end

  // Byte-masked write into the granted row; contents are never reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NUM_BANKS; b++)
      if (bank_go[b] && bank_we[b])
        for (int k = 0; k < BE_W; k++)
          if (bank_be[b][k]) mem[b][bank_row[b]][k*8 +: 8] <= bank_wdata[b][k*8 +: 8];
  end

  // ---- stage p1: response ----

  // Response valid one cycle after grant; read data latched, held across write acks.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1 <= '0;
      for (int p = 0; p < NUM_PORTS; p++) rdata_p1[p] <= '0;
    end else begin
      vld_p1 <= gnt_p0;
      for (int p = 0; p < NUM_PORTS; p++)
        if (gnt_p0[p] && !bus.we_i[p]) rdata_p1[p] <= mem[bank_of_p0[p]][row_of_p0[p]];
    end
  end

  assign bus.rvalid_o = vld_p1;

  // Flatten per-port read registers onto the output bus.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++)
      bus.data_o[p*DATA_WIDTH +: DATA_WIDTH] = rdata_p1[p];
  end
endmodule
